// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a first-word-fall-through FIFO of {flags, data} entries.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote around the sample point.
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 2,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int RTS_MARGIN  = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 Pop_Data,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS,
  output logic                 Rx_Busy
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BCW = 4;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WW  = DATA_BITS + 3;
  localparam logic ODD = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  logic rx_m, rx_s, bit_s;
  state_t state, state_n;
  logic [TW-1:0]        tick;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_err, par_low, frm_err;
  logic                 tick_end, last_data, first_stop, last_stop, is_break;
  logic                 push_now, push_q;
  logic [2:0]           push_flags;
  logic [WW-1:0]        push_word;

  always_ff @(posedge Clk) begin
    if (Rst) {rx_s, rx_m} <= 2'b11;
    else     {rx_s, rx_m} <= {rx_m, Rx};
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote over the last three synchronised samples; the middle one is the bit centre.
  logic [1:0] rx_h;
  always_ff @(posedge Clk) begin
    if (Rst) rx_h <= 2'b11;
    else     rx_h <= {rx_h[0], rx_s};
  end
  assign bit_s = (rx_h[1] & rx_h[0]) | (rx_h[0] & rx_s) | (rx_h[1] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  always_comb begin
    tick_end   = (state == S_START) ? (tick == TW'(OVERSAMPLE/2 - 1))
                                    : (tick == TW'(OVERSAMPLE - 1));
    last_data  = (bit_cnt == BCW'(DATA_BITS - 1));
    first_stop = (bit_cnt == '0);
    last_stop  = (bit_cnt == BCW'(STOP_BITS - 1));
    is_break   = (data_sr == '0) && par_low && !bit_s;
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!rx_s) state_n = S_START;
      S_START: if (tick_end) state_n = bit_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick_end && last_data) state_n = (PARITY_MODE != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tick_end) state_n = S_STOP;
      S_STOP:  if (tick_end) begin
                 if (first_stop && is_break) state_n = S_BRK;
                 else if (last_stop)         state_n = S_IDLE;
               end
      S_BRK:   if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Rx_Busy    = (state != S_IDLE);
    push_now   = (state == S_STOP) && tick_end && ((first_stop && is_break) || last_stop);
    push_flags = (first_stop && is_break) ? 3'b001 : {frm_err | ~bit_s, par_err, 1'b0};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tick      <= '0;
      bit_cnt   <= '0;
      data_sr   <= '0;
      par_err   <= 1'b0;
      par_low   <= 1'b1;
      frm_err   <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= push_now;
      if (push_now)
        push_word <= {push_flags, push_flags[0] ? {DATA_BITS{1'b0}} : data_sr};
      if (state == S_IDLE) begin
        tick    <= '0;
        bit_cnt <= '0;
        par_err <= 1'b0;
        par_low <= 1'b1;
        frm_err <= 1'b0;
      end else begin
        tick <= tick_end ? '0 : tick + 1'b1;
      end
      if (tick_end) begin
        case (state)
          S_DATA: begin
            data_sr <= {bit_s, data_sr[DATA_BITS-1:1]};
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
          end
          S_PAR: begin
            par_err <= (^data_sr) ^ bit_s ^ ODD;
            par_low <= !bit_s;
          end
          S_STOP: begin
            frm_err <= frm_err | !bit_s;
            bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, cnt_n, free_n;
  logic          do_push, do_pop;
  logic [WW-1:0] head;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    do_pop  = Pop_Data && (count != '0);
    do_push = push_q && ((count != CW'(FIFO_DEPTH)) || do_pop);
    cnt_n   = count + CW'(do_push) - CW'(do_pop);
    free_n  = CW'(FIFO_DEPTH) - cnt_n;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      FIFO_Empty    <= 1'b1;
      FIFO_Full     <= 1'b0;
      FIFO_Overflow <= 1'b0;
      RTS           <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= cnt_n;
      FIFO_Empty <= (cnt_n == '0);
      FIFO_Full  <= (cnt_n == CW'(FIFO_DEPTH));
      RTS        <= (free_n > CW'(RTS_MARGIN));
      if (push_q && !do_push) FIFO_Overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push && !Rst) mem[wr_ptr] <= push_word;
  end

  assign head     = mem[rd_ptr];
  assign Data_Out = FIFO_Empty ? '0 : head[DATA_BITS-1:0];
  assign Rx_Error = FIFO_Empty ? '0 : head[WW-1:DATA_BITS];
  assign Data_Rdy = !FIFO_Empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (8E2, 16x, 16-deep FIFO).
module tb_uart_rx_fifo;
  logic       Clk = 1'b0;
  logic       Rst, Rx, Pop_Data;
  logic [7:0] Data_Out;
  logic [2:0] Rx_Error;
  logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Busy;
  int         nchk = 0;
  int         nfail = 0;

  always #5 Clk = ~Clk;

  uart_rx_fifo dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Pop_Data(Pop_Data),
    .Data_Out(Data_Out), .Rx_Error(Rx_Error), .Data_Rdy(Data_Rdy),
    .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full), .FIFO_Overflow(FIFO_Overflow),
    .RTS(RTS), .Rx_Busy(Rx_Busy)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every task returns 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic badpar, input logic [1:0] stp);
    logic [11:0] b;
    b = {stp, (^d) ^ badpar, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      Rx = b[i];
      tick(16);
    end
    Rx = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input int exp);
    chk(tag, int'({Rx_Error, Data_Out}), exp);
    Pop_Data = 1'b1;
    tick(1);
    Pop_Data = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] d;
    Rst = 1'b1; Rx = 1'b1; Pop_Data = 1'b0;
    tick(3);
    Rst = 1'b0;
    tick(1);
    chk("rst_dout",  int'(Data_Out), 0);
    chk("rst_err",   int'(Rx_Error), 0);
    chk("rst_rdy",   int'(Data_Rdy), 0);
    chk("rst_empty", int'(FIFO_Empty), 1);
    chk("rst_full",  int'(FIFO_Full), 0);
    chk("rst_ovf",   int'(FIFO_Overflow), 0);
    chk("rst_busy",  int'(Rx_Busy), 0);
    chk("rst_rts",   int'(RTS), 1);

    // clean 0xA5 frame
    send(8'hA5, 1'b0, 2'b11);
    tick(2);
    chk("a5_rdy", int'(Data_Rdy), 1);
    chk("a5_busy", int'(Rx_Busy), 0);
    pop_chk("a5_word", 'h0A5);
    chk("a5_empty", int'(FIFO_Empty), 1);
    chk("a5_dout0", int'(Data_Out), 0);

    // parity error then frame error
    send(8'hAA, 1'b1, 2'b11);
    send(8'hAA, 1'b0, 2'b00);
    tick(2);
    pop_chk("par_err", 'h2AA);
    pop_chk("frm_err", 'h4AA);
    chk("err_empty", int'(FIFO_Empty), 1);

    // break held long, then a normal frame
    Rx = 1'b0;
    tick(192 + 400);
    chk("brk_busy", int'(Rx_Busy), 1);
    chk("brk_rdy", int'(Data_Rdy), 1);
    Rx = 1'b1;
    tick(32);
    chk("brk_idle", int'(Rx_Busy), 0);
    send(8'h3C, 1'b0, 2'b11);
    tick(2);
    pop_chk("brk_word", 'h100);
    pop_chk("post_brk", 'h03C);
    chk("brk_empty", int'(FIFO_Empty), 1);

    // fill to overflow, no pops
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b0, 2'b11);
      if (i == 12) chk("rts_13", int'(RTS), 1);
      if (i == 13) chk("rts_14", int'(RTS), 0);
      if (i == 14) chk("full_15", int'(FIFO_Full), 0);
      if (i == 15) chk("full_16", int'(FIFO_Full), 1);
      if (i == 15) chk("ovf_16", int'(FIFO_Overflow), 0);
      if (i == 16) chk("ovf_17", int'(FIFO_Overflow), 1);
    end
    tick(2);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("ord%0d", i), i);
    chk("ord_empty", int'(FIFO_Empty), 1);
    chk("ovf_sticky", int'(FIFO_Overflow), 1);

    // full FIFO, pop coincides with the push
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    tick(1);
    chk("ovf_clr", int'(FIFO_Overflow), 0);
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0, 2'b11);
    fork
      send(8'h77, 1'b0, 2'b11);
      begin
        n = 0;
        while (!Rx_Busy && n < 400) begin tick(1); n++; end
        while (Rx_Busy && n < 400) begin tick(1); n++; end
        chk("busy_wait", int'(n < 400), 1);
        Pop_Data = 1'b1;
        tick(1);
        Pop_Data = 1'b0;
      end
    join
    tick(2);
    chk("pp_full", int'(FIFO_Full), 1);
    chk("pp_ovf", int'(FIFO_Overflow), 0);
    for (int i = 1; i < 16; i++) pop_chk($sformatf("pp%0d", i), 'h40 + i);
    pop_chk("pp_new", 'h077);
    chk("pp_empty", int'(FIFO_Empty), 1);

    // false start
    Rx = 1'b0;
    tick(5);
    chk("fs_busy", int'(Rx_Busy), 1);
    Rx = 1'b1;
    tick(30);
    chk("fs_idle", int'(Rx_Busy), 0);
    chk("fs_empty", int'(FIFO_Empty), 1);

    // reset mid-frame
    send(8'h11, 1'b0, 2'b11);
    tick(2);
    chk("pre_rst_rdy", int'(Data_Rdy), 1);
    d = 8'h5A;
    Rx = 1'b0;
    tick(16);
    for (int j = 0; j < 4; j++) begin
      Rx = d[j];
      tick(16);
    end
    Rx = d[4];
    tick(8);
    chk("mid_busy", int'(Rx_Busy), 1);
    Rst = 1'b1;
    Rx = 1'b1;
    tick(1);
    Rst = 1'b0;
    chk("mrst_busy", int'(Rx_Busy), 0);
    chk("mrst_empty", int'(FIFO_Empty), 1);
    chk("mrst_dout", int'(Data_Out), 0);
    tick(20);
    send(8'h5A, 1'b0, 2'b11);
    tick(2);
    pop_chk("post_rst", 'h05A);
    chk("post_empty", int'(FIFO_Empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
